window_sum_ctrl: RTL and testbench
==================================

// Module: window_sum_ctrl
// PURPOSE
//  Sequences a WIN x WIN window sum of per-pixel difference values for the motion detector.
//  Instead of summing all pixels combinationally in one pass, it walks the window one pixel per clock:
//   - issues row/col read addresses to the diff-pixel buffer (1-cycle read latency),
//   - accumulates the returned values with saturation,
//   - then publishes the sum and a motion flag (sum > threshold) with a one-cycle done pulse.
// PARAMETERS
//  WIN    11  window side; the window has WIN*WIN pixels; row/col range 0..WIN-1
//  PIX_W  8   width of one diff pixel
//  SUM_W  16  width of the accumulator, sum_out and thr
//  IDX_W  4   width of rd_row/rd_col; must satisfy 2**IDX_W >= WIN
// PORTS
//  clk      in   1      system clock; all state changes on the rising edge
//  reset    in   1      synchronous, active-high reset
//  start    in   1      request one window sum; accepted only in IDLE
//  abort    in   1      cancel the scan in progress; no done pulse
//  thr      in   SUM_W  motion threshold; sampled when start is accepted
//  rd_en    out  1      read strobe to the pixel buffer
//  rd_row   out  IDX_W  read row index
//  rd_col   out  IDX_W  read column index
//  rd_data  in   PIX_W  buffer data; valid exactly one cycle after rd_en
//  busy     out  1      high from the cycle after acceptance through DRAIN
//  done     out  1      one-cycle pulse when sum_out/motion are updated
//  sum_out  out  SUM_W  last completed window sum; held between scans
//  motion   out  1      last completed result, (sum_out > thr_latched)
// BEHAVIOUR
//  Reset: state=IDLE. Every output is 0: rd_en, rd_row, rd_col, busy, done, sum_out, motion.
//   The accumulator, the data-valid pipe and the latched threshold also reset to 0.
//   Reset has priority over every other input and aborts a scan in progress.
//  IDLE: if start=1 (and abort=0):
//   - clear the accumulator, latch thr, set row=col=0, go to FETCH.
//   - done is 0 in every state except the cycle right after DRAIN.
//  FETCH: rd_en=1 every cycle, addressing (rd_row, rd_col).
//   - col increments each cycle; at WIN-1 it wraps to 0 and row increments (row-major order).
//   - The cycle that issues (WIN-1, WIN-1) moves to DRAIN.
//   - Exactly WIN*WIN reads per scan; no address is skipped or repeated.
//  Data pipe: a valid bit is registered from rd_en.
//   - When valid=1, acc <= sat(acc + rd_data).
//   - sat clamps at 2**SUM_W-1; once clamped, acc stays there.
//  DRAIN: rd_en=0; the last read's data is accumulated. On the closing edge:
//   - sum_out <= sat(acc + rd_data)
//   - motion  <= (that value > thr_latched); strictly greater, equality gives 0
//   - done <= 1; state -> IDLE
//  Timing, with start sampled at edge E0:
//   - FETCH occupies cycles 1..WIN*WIN; DRAIN is cycle WIN*WIN+1.
//   - done is high in cycle WIN*WIN+2 (123 cycles for WIN=11).
//   - busy is high in cycles 1..WIN*WIN+1.
//  Start handling:
//   - start while busy is ignored (not queued).
//   - start in the done cycle is accepted (state is IDLE), so back-to-back scans run with no gap.
//  Abort: abort=1 in FETCH or DRAIN goes to IDLE on that edge.
//   - rd_en, busy and the data pipe clear.
//   - No done pulse; sum_out and motion keep their previous values.
//   - abort in IDLE is ignored; abort has priority over start.
//  thr changes during a scan have no effect (the latched value is used).
// TESTING
//  1. reset, start with all rd_data=0, thr=0 -> 121 reads in row-major order;
//     done at cycle 123 with sum_out=0, motion=0; busy high for cycles 1..122.
//  2. all rd_data=255, thr=1000 -> sum_out=30855, motion=1.
//     Same data with SUM_W=12 -> sum_out=4095 (saturated).
//  3. rd_data=row+col:
//     - thr=1210 -> sum_out=1210, motion=0;
//     - rerun with thr=1209 -> motion=1.
//  4. abort in cycle 50 of a scan following test 3:
//     - rd_en/busy are 0 from the next cycle and there is no done pulse;
//     - sum_out stays 1210;
//     - a fresh start then completes normally.
//  5. start asserted during FETCH is ignored (still one done at 123).
//     start in the done cycle begins a new scan at once: a second done 123 cycles later.
//  6. reset asserted mid-FETCH -> next cycle all outputs are 0 and state is IDLE;
//     a start after release gives a correct sum.

Source files
------------

// File: rtl/window_sum_ctrl_if.sv
// rtl/window_sum_ctrl_if.sv - read bus between the window-sum sequencer and the diff-pixel buffer
interface window_sum_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int PIX_W = 8
);
  logic             rd_en;
  logic [IDX_W-1:0] rd_row;
  logic [IDX_W-1:0] rd_col;
  logic [PIX_W-1:0] rd_data;

  modport master (output rd_en, output rd_row, output rd_col, input rd_data);
  modport slave  (input rd_en, input rd_row, input rd_col, output rd_data);
endinterface

// File: rtl/window_sum_ctrl.sv
// rtl/window_sum_ctrl.sv - walks a WIN x WIN window one pixel per clock and publishes a saturated sum plus motion flag
module window_sum_ctrl #(
  parameter int WIN   = 11,
  parameter int PIX_W = 8,
  parameter int SUM_W = 16,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [SUM_W-1:0]   thr,
  window_sum_ctrl_if.master  rd,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   sum_out,
  output logic               motion
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIN - 1);

  state_t           state;
  logic             valid;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] thr_l;
  logic [SUM_W-1:0] acc_next;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [PIX_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - PIX_W){1'b0}}, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  // Buffer data lags the strobe by one cycle, so valid qualifies what rd_data holds now.
  assign acc_next = sat_add(acc, rd.rd_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= 1'b0;
      acc       <= '0;
      thr_l     <= '0;
      rd.rd_en  <= 1'b0;
      rd.rd_row <= '0;
      rd.rd_col <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      motion    <= 1'b0;
    end else begin
      done  <= 1'b0;
      valid <= rd.rd_en;
      if (valid) acc <= acc_next;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            acc       <= '0;
            thr_l     <= thr;
            rd.rd_row <= '0;
            rd.rd_col <= '0;
            rd.rd_en  <= 1'b1;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            rd.rd_en <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            state    <= IDLE;
          end else if (rd.rd_col == LAST) begin
            rd.rd_col <= '0;
            if (rd.rd_row == LAST) begin
              rd.rd_en <= 1'b0;
              state    <= DRAIN;
            end else begin
              rd.rd_row <= rd.rd_row + 1'b1;
            end
          end else begin
            rd.rd_col <= rd.rd_col + 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            valid <= 1'b0;
            state <= IDLE;
          end else begin
            sum_out <= acc_next;
            motion  <= (acc_next > thr_l);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_sum_ctrl.sv
// tb/tb_window_sum_ctrl.sv - self-checking bench for window_sum_ctrl
module tb_window_sum_ctrl;
  localparam int WIN = 11;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] thr;
  logic        busy, done, motion;
  logic [15:0] sum_out;
  logic        busy2, done2, motion2;
  logic [11:0] sum2;

  always #5 clk = ~clk;

  window_sum_ctrl_if #(.IDX_W(4), .PIX_W(8)) rd  ();
  window_sum_ctrl_if #(.IDX_W(4), .PIX_W(8)) rd2 ();

  window_sum_ctrl #(.WIN(WIN), .PIX_W(8), .SUM_W(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .thr(thr),
    .rd(rd), .busy(busy), .done(done), .sum_out(sum_out), .motion(motion)
  );

  window_sum_ctrl #(.WIN(WIN), .PIX_W(8), .SUM_W(12), .IDX_W(4)) dut12 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .thr(thr[11:0]),
    .rd(rd2), .busy(busy2), .done(done2), .sum_out(sum2), .motion(motion2)
  );

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int rand_pix [WIN][WIN];
  int rd_log [$];
  logic logging = 1'b0;

  function automatic int pix(input int m, input int r, input int c);
    case (m)
      0:       return 0;
      1:       return 255;
      2:       return r + c;
      default: return rand_pix[r][c];
    endcase
  endfunction

  // Reference: saturating sequential addition of non-negative values equals the clamped total.
  function automatic int model_sum(input int m, input int sumw);
    int total = 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        total += pix(m, r, c);
    if (total > (1 << sumw) - 1) total = (1 << sumw) - 1;
    return total;
  endfunction

  always @(posedge clk) begin
    if (rd.rd_en)  rd.rd_data  <= 8'(pix(mode, int'(rd.rd_row), int'(rd.rd_col)));
    if (rd2.rd_en) rd2.rd_data <= 8'(pix(mode, int'(rd2.rd_row), int'(rd2.rd_col)));
  end

  always @(negedge clk)
    if (logging && rd.rd_en) rd_log.push_back(int'(rd.rd_row) * 16 + int'(rd.rd_col));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is 1 time unit after a rising edge; start is sampled at the next edge (E0).
  task automatic run_scan(input int m, input int t, input int exp_sum, input int exp_mot, input string tag);
    int cyc, busy_cnt, first_busy, last_busy, done_cyc, ord_err;
    busy_cnt = 0; first_busy = -1; last_busy = -1; done_cyc = -1; ord_err = 0;
    mode = m; thr = 16'(t);
    rd_log.delete();
    logging = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (cyc <= 200) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
        last_busy = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    logging = 1'b0;
    @(posedge clk); #1;
    if (done_cyc < 0) $display("FAIL %s timeout: got no done expected done at cycle %0d", tag, WIN * WIN + 2);
    chk({tag, " done_cycle"}, done_cyc, WIN * WIN + 2);
    chk({tag, " busy_cycles"}, busy_cnt, WIN * WIN + 1);
    chk({tag, " busy_first"}, first_busy, 1);
    chk({tag, " busy_last"}, last_busy, WIN * WIN + 1);
    chk({tag, " read_count"}, rd_log.size(), WIN * WIN);
    for (int i = 0; i < rd_log.size(); i++)
      if (rd_log[i] != (i / WIN) * 16 + (i % WIN)) ord_err++;
    chk({tag, " read_order_errors"}, ord_err, 0);
    chk({tag, " sum_out"}, sum_out, exp_sum);
    chk({tag, " motion"}, motion, exp_mot);
    chk({tag, " sum_out_w12"}, sum2, model_sum(m, 12));
  endtask

  typedef struct {
    int    m;
    int    t;
    int    exp_sum;
    int    exp_mot;
    string tag;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int dn, cyc, d1, d2, ex, t;
    vecs[0] = '{0, 0,    0,     0, "zeros"};
    vecs[1] = '{1, 1000, 30855, 1, "all255"};
    vecs[2] = '{2, 1210, 1210,  0, "rowcol_eq"};
    vecs[3] = '{2, 1209, 1210,  1, "rowcol_gt"};

    reset = 1'b1; start = 1'b0; abort = 1'b0; thr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset rd_en", rd.rd_en, 0);
    chk("reset rd_row", rd.rd_row, 0);
    chk("reset rd_col", rd.rd_col, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum_out", sum_out, 0);
    chk("reset motion", motion, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run_scan(vecs[i].m, vecs[i].t, vecs[i].exp_sum, vecs[i].exp_mot, vecs[i].tag);

    // Abort sampled at the end of cycle 50; prior result (1210, motion=1) must survive.
    mode = 2; thr = 16'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (49) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort rd_en", rd.rd_en, 0);
    chk("abort busy", busy, 0);
    dn = 0;
    repeat (150) begin @(negedge clk); if (done) dn++; end
    chk("abort done_pulses", dn, 0);
    chk("abort sum_held", sum_out, 1210);
    chk("abort motion_held", motion, 1);
    @(posedge clk); #1;
    run_scan(2, 1210, 1210, 0, "after_abort");

    // Start at cycle 30 is ignored; start in the done cycle chains a second scan.
    mode = 1; thr = 16'd1000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d1 = -1; d2 = -1; dn = 0;
    for (cyc = 1; cyc <= 260; cyc++) begin
      start = (cyc == 30 || cyc == WIN * WIN + 2);
      @(negedge clk);
      if (done) begin
        dn++;
        if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b done_count", dn, 2);
    chk("b2b first_done", d1, WIN * WIN + 2);
    chk("b2b second_done", d2, 2 * (WIN * WIN + 2));
    chk("b2b sum_out", sum_out, 30855);

    // Reset mid-FETCH at cycle 40.
    mode = 2; thr = 16'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset rd_en", rd.rd_en, 0);
    chk("midreset rd_row", rd.rd_row, 0);
    chk("midreset rd_col", rd.rd_col, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset sum_out", sum_out, 0);
    chk("midreset motion", motion, 0);
    chk("midreset sum_out_w12", sum2, 0);
    @(posedge clk); #1;
    run_scan(2, 1210, 1210, 0, "after_reset");

    // Random pixels; threshold straddles the model sum to hit the strict comparison.
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          rand_pix[r][c] = $urandom_range(0, (k < 2) ? 30 : 255);
      ex = model_sum(3, 16);
      t = ex - 1 + $urandom_range(0, 2);
      run_scan(3, t, ex, (ex > t) ? 1 : 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
